fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR lowpass engine that shares one signed multiplier-accumulator across all taps.
- Accepts input samples over a valid/ready handshake and keeps them in a circular delay line of TAPS entries.
- Sequences one MAC per tap, then presents a Q15-scaled, saturated output over a valid/ready handshake.
- Sits between the sample source (ADC/stimulus interface) and the downstream sink. Replaces the parallel tap-per-register structure when area matters. Coefficients are programmable at run time.

---
 rtl/fir_pkg.sv | 47 ++++
 rtl/fir_delay_ram.sv | 39 +++
 rtl/fir_mac_sequencer.sv | 136 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the filter blocks.
//   FIR_DATA_W / FIR_COEF_W : default sample and coefficient widths
//   ST_IDLE / ST_MAC / ST_OUT : state encoding of the MAC sequencer
//   fir_state_t             : enum built on that encoding
//   sat_shift()             : arithmetic right shift followed by clamping
//                             to a signed out_w-bit range
// ---------------------------------------------------------------------------
package fir_pkg;

   localparam int FIR_DATA_W = 16;
   localparam int FIR_COEF_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      MAC  = ST_MAC,
      OUT  = ST_OUT
   } fir_state_t;

   // Shift truncates toward minus infinity (no rounding). The caller
   // sign-extends its accumulator to 64 bits and keeps the low out_w bits
   // of the result, which are already inside the clamp range.
   function automatic logic signed [63:0] sat_shift(
      input logic signed [63:0] val,
      input int                 shift,
      input int                 out_w
   );
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = val >>> shift;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (s > hi)
         sat_shift = hi;
      else if (s < lo)
         sat_shift = lo;
      else
         sat_shift = s;
   endfunction

endpackage

// File: rtl/fir_delay_ram.sv
// ---------------------------------------------------------------------------
// fir_delay_ram
// DEPTH x W register array used as the circular sample delay line.
//   clk   : rising-edge clock
//   clr   : synchronous clear of every entry
//   we    : write strobe
//   waddr : write index
//   wdata : write data
//   raddr : read index (combinational read)
//   rdata : contents of entry raddr
// ---------------------------------------------------------------------------
module fir_delay_ram #(
   parameter int DEPTH = 3,
   parameter int W     = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer
// Time-multiplexed FIR filter: one signed MAC is shared across all taps.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : sample input handshake, in_data signed sample
//   coef_we/addr/wdata  : coefficient write port (honoured in IDLE only)
//   out_valid/out_ready : result output handshake, out_data signed result
//   busy                : high whenever the engine is not IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// OUT, and out_data is held stable until out_ready completes the transfer.
// ---------------------------------------------------------------------------
module fir_mac_sequencer
   import fir_pkg::*;
#(
   parameter int TAPS      = 3,
   parameter int DATA_W    = FIR_DATA_W,
   parameter int COEF_W    = FIR_COEF_W,
   parameter int OUT_SHIFT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic [COEF_W-1:0]        coef_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     busy
);

   localparam int PTR_W  = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(TAPS - 1);
   localparam logic [PTR_W:0]   TAPS_EXT = (PTR_W + 1)'(TAPS);

   fir_state_t               state;
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [PTR_W-1:0]         k;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [PROD_W-1:0] prod;
   logic signed [COEF_W-1:0] coef [TAPS];
   logic [DATA_W-1:0]        rd_data;
   logic                     accept;
   logic                     coef_ok;

   assign accept  = in_valid && in_ready;
   // Addresses at or beyond TAPS are dropped rather than aliased.
   assign coef_ok = {1'b0, coef_addr} < TAPS_EXT;

   fir_delay_ram #(
      .DEPTH (TAPS),
      .W     (DATA_W)
   ) u_delay (
      .clk   (clk),
      .clr   (rst),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   // Full-precision product, sign-extended into the guard bits of acc.
   always_comb begin
      prod     = $signed(rd_data) * coef[k];
      acc_next = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         k         <= '0;
         acc       <= '0;
         out_data  <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < TAPS; i++)
            coef[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A write here is seen by a sample accepted in this same
               // cycle, because the MAC pass starts on the next edge.
               if (coef_we && coef_ok)
                  coef[coef_addr] <= coef_wdata;
               if (accept) begin
                  rd_ptr   <= wr_ptr;
                  wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                  k        <= '0;
                  acc      <= '0;
                  state    <= MAC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            MAC: begin
               // Walk from the newest sample backwards in time.
               acc    <= acc_next;
               rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
               k      <= k + 1'b1;
               if (k == LAST) begin
                  out_data  <= DATA_W'(sat_shift(64'(acc_next), OUT_SHIFT, DATA_W));
                  state     <= OUT;
                  out_valid <= 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

   localparam int TAPS      = 3;
   localparam int DATA_W    = 16;
   localparam int COEF_W    = 16;
   localparam int OUT_SHIFT = 15;
   localparam int AW        = $clog2(TAPS);

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              coef_we = 1'b0;
   logic [AW-1:0]     coef_addr = '0;
   logic [COEF_W-1:0] coef_wdata = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   always #5 clk = ~clk;

   fir_mac_sequencer #(
      .TAPS      (TAPS),
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   // ---------------- scoreboard / reference model ----------------
   int                n_checks = 0;
   int                n_errors = 0;
   logic [DATA_W-1:0] exp_q[$];
   longint            hist[$];       // index 0 = newest sample
   longint            coef_m[TAPS];

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic longint model_out();
      longint sum = 0;
      longint lim_hi = (64'sd1 <<< (DATA_W - 1)) - 1;
      longint lim_lo = -(64'sd1 <<< (DATA_W - 1));
      for (int i = 0; i < TAPS; i++)
         sum += hist[i] * coef_m[i];
      sum = sum >>> OUT_SHIFT;
      if (sum > lim_hi) sum = lim_hi;
      if (sum < lim_lo) sum = lim_lo;
      return sum;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < TAPS; i++) begin
         hist.push_back(0);
         coef_m[i] = 0;
      end
   endtask

   task automatic model_sample(input longint x);
      hist.push_front(x);
      void'(hist.pop_back());
      exp_q.push_back(DATA_W'(model_out()));
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   // Only called while the DUT is idle.
   task automatic write_coef(input int addr, input longint val);
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = AW'(addr);
      coef_wdata = COEF_W'(val);
      if (addr < TAPS) coef_m[addr] = val;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic send_sample(input longint x, input int hold, input bit cw,
                              input int caddr, input longint cval,
                              input bit busy_wr, output longint got);
      int waited = 0;
      int lat = 0;
      logic [DATA_W-1:0] e;
      logic [DATA_W-1:0] held;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("in_ready_before_accept", longint'(in_ready), 1);
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      in_data   = DATA_W'(x);
      if (cw) begin
         coef_we    = 1'b1;
         coef_addr  = AW'(caddr);
         coef_wdata = COEF_W'(cval);
         if (caddr < TAPS) coef_m[caddr] = cval;
      end
      model_sample(x);
      @(posedge clk); #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         coef_we = 1'b0;
         if (out_valid) break;
         if (lat == 1) begin
            check("busy_in_mac", longint'(busy), 1);
            check("in_ready_in_mac", longint'(in_ready), 0);
            if (busy_wr) begin
               coef_we    = 1'b1;
               coef_addr  = '0;
               coef_wdata = '0;
            end
         end
      end
      check("latency", lat, TAPS);
      got = longint'($signed(out_data));
      e = exp_q.pop_front();
      check("out_data", got, longint'($signed(e)));
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", longint'(out_valid), 1);
         check("bp_out_data_stable", longint'(out_data), longint'(held));
         check("bp_in_ready", longint'(in_ready), 0);
         check("bp_busy", longint'(busy), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_out_valid", longint'(out_valid), 0);
      check("idle_in_ready", longint'(in_ready), 1);
      check("idle_busy", longint'(busy), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      longint got;
      longint x;
      int     hold;
      int     ca;
      longint cv;
      bit     cw;

      // Reset / idle state
      do_reset();
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_out_data", longint'(out_data), 0);

      // Impulse/step with c = {16384, 8192, 8192}
      write_coef(0, 16384);
      write_coef(1, 8192);
      write_coef(2, 8192);
      send_sample(1000, 0, 0, 0, 0, 0, got); check("step_1000", got, 500);
      send_sample(2000, 0, 0, 0, 0, 0, got); check("step_2000", got, 1250);
      send_sample(4000, 0, 0, 0, 0, 0, got); check("step_4000", got, 2750);

      // Saturation, both rails
      do_reset();
      for (int i = 0; i < TAPS; i++) write_coef(i, 32767);
      for (int i = 0; i < 3; i++) send_sample(32767, 0, 0, 0, 0, 0, got);
      check("sat_high", got, 32767);
      for (int i = 0; i < 3; i++) send_sample(-32768, 0, 0, 0, 0, 0, got);
      check("sat_low", got, -32768);

      // Backpressure
      send_sample(1234, 10, 0, 0, 0, 0, got);

      // Coefficient writes while busy vs. with accept in IDLE
      do_reset();
      write_coef(0, 16384);
      write_coef(1, 8192);
      write_coef(2, 8192);
      send_sample(1000, 0, 0, 0, 0, 1, got); check("coef_busy_ignored", got, 500);
      send_sample(2000, 0, 1, 0, 0, 0, got); check("coef_with_accept", got, 250);
      write_coef(3, 32767);
      send_sample(0, 0, 0, 0, 0, 0, got);    check("coef_addr_oob", got, 750);

      // Reset in the middle of a MAC pass
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'(7777);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("abort_out_valid", longint'(out_valid), 0);
         check("abort_busy", longint'(busy), 0);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < TAPS + 2; i++) begin
         @(posedge clk); #1;
         check("abort_no_result", longint'(out_valid), 0);
      end
      write_coef(0, 16384);
      write_coef(1, 8192);
      write_coef(2, 8192);
      send_sample(1000, 0, 0, 0, 0, 0, got); check("after_abort", got, 500);

      // Randomized traffic against the reference model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0)
            write_coef(int'($urandom_range(0, 3)), longint'($urandom_range(0, 65535)) - 32768);
         x    = longint'($urandom_range(0, 65535)) - 32768;
         hold = int'($urandom_range(0, 3));
         cw   = ($urandom_range(0, 4) == 0);
         ca   = int'($urandom_range(0, 3));
         cv   = longint'($urandom_range(0, 65535)) - 32768;
         send_sample(x, hold, cw, ca, cv, bit'($urandom_range(0, 1)), got);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
